// File: rtl/bp_pkg.sv
// bp_pkg: types shared by the tournament predictor blocks.
package bp_pkg;
    typedef enum logic [1:0] {SL = 2'b00, WL = 2'b01, WG = 2'b10, SG = 2'b11} tourn_sel_t;
    localparam tourn_sel_t TOURN_INIT = WL;
    localparam int BP_IDX_W = 6;
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        tourn_sel_t          sel;
    } bp_upd_t;
    typedef enum logic {ST_INIT, ST_RUN} ct_state_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: selector write-back FIFO; entries are exposed oldest-first for the forwarding compare.
module bp_upd_fifo import bp_pkg::*; #(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_i,
    input  logic [IDX_W-1:0]                  push_idx_i,
    input  logic [1:0]                        push_sel_i,
    input  logic                              pop_i,
    output logic [$clog2(QDEPTH):0]           count_o,
    output logic [QDEPTH-1:0][IDX_W-1:0]      ent_idx_o,
    output logic [QDEPTH-1:0][1:0]            ent_sel_o,
    output logic [QDEPTH-1:0]                 ent_vld_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    logic [QDEPTH-1:0][IDX_W+1:0] mem_q;
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_i ? wr_q + PW'(1) : wr_q;
            rd_q  <= pop_i ? rd_q + PW'(1) : rd_q;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= {push_idx_i, push_sel_i};
    end
    assign count_o = cnt_q;
    genvar i;
    generate
        for (i = 0; i < QDEPTH; i++) begin : g_ent
            logic [PW-1:0] a;
            assign a            = rd_q + PW'(i);
            assign ent_idx_o[i] = mem_q[a][IDX_W+1:2];
            assign ent_sel_o[i] = mem_q[a][1:0];
            assign ent_vld_o[i] = CW'(i) < cnt_q;
        end
    endgenerate
endmodule

// File: rtl/bp_choice_table_sched.sv
// bp_choice_table_sched: shares the single-port tournament choice table between fetch lookups
// and buffered MEM write-backs, with store-to-lookup forwarding and a post-reset init sweep.
module bp_choice_table_sched import bp_pkg::*; #(
    parameter int         IDX_W    = 6,
    parameter int         QDEPTH   = 4,
    parameter logic [1:0] INIT_SEL = TOURN_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_i,
    input  logic [IDX_W-1:0] if_idx_i,
    output logic             if_ready_o,
    output logic             if_rsp_valid_o,
    output logic [1:0]       if_rsp_sel_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [1:0]       upd_sel_i,
    output logic             upd_ready_o,
    output logic             tbl_en_o,
    output logic             tbl_we_o,
    output logic [IDX_W-1:0] tbl_addr_o,
    output logic [1:0]       tbl_wdata_o,
    input  logic [1:0]       tbl_rdata_i,
    output logic             init_done_o
);
    localparam int CW = $clog2(QDEPTH) + 1;
    ct_state_t state_q;
    logic [IDX_W-1:0] sweep_q;
    logic init_done_q, rsp_valid_q, hit_q, hit_d;
    logic [1:0] fwd_q, fwd_d;
    logic [CW-1:0] cnt;
    logic [QDEPTH-1:0][IDX_W-1:0] ent_idx;
    logic [QDEPTH-1:0][1:0] ent_sel;
    logic [QDEPTH-1:0] ent_vld;
    logic run, full, accept, pop, push;
    bp_upd_fifo #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_idx_i (upd_idx_i),
        .push_sel_i (upd_sel_i),
        .pop_i      (pop),
        .count_o    (cnt),
        .ent_idx_o  (ent_idx),
        .ent_sel_o  (ent_sel),
        .ent_vld_o  (ent_vld)
    );
    assign run         = state_q == ST_RUN;
    assign full        = cnt == CW'(QDEPTH);
    assign if_ready_o  = run && !full;
    assign upd_ready_o = run && !full;
    assign accept      = if_ready_o && if_req_i;
    assign pop         = run && (full || (!if_req_i && cnt != '0));
    assign push        = upd_valid_i && upd_ready_o;
    // rst gates the table port so nothing is touched while reset is held
    assign tbl_en_o    = !rst && (!run || accept || pop);
    assign tbl_we_o    = !rst && (!run || pop);
    assign tbl_addr_o  = !run ? sweep_q : accept ? if_idx_i : ent_idx[0];
    assign tbl_wdata_o = !run ? INIT_SEL : ent_sel[0];
    // later matches overwrite earlier ones: younger entries, then the incoming update, win
    always_comb begin
        hit_d = 1'b0;
        fwd_d = 2'b00;
        for (int k = 0; k < QDEPTH; k++) begin
            if (ent_vld[k] && !(pop && k == 0) && ent_idx[k] == if_idx_i) begin
                hit_d = 1'b1;
                fwd_d = ent_sel[k];
            end
        end
        if (push && upd_idx_i == if_idx_i) begin
            hit_d = 1'b1;
            fwd_d = upd_sel_i;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            fwd_q       <= 2'b00;
        end else begin
            if (state_q == ST_INIT) begin
                sweep_q <= sweep_q + IDX_W'(1);
                if (sweep_q == '1) begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            end
            rsp_valid_q <= accept;
            if (accept) begin
                hit_q <= hit_d;
                fwd_q <= fwd_d;
            end
        end
    end
    assign init_done_o    = init_done_q;
    assign if_rsp_valid_o = rsp_valid_q;
    assign if_rsp_sel_o   = !rsp_valid_q ? 2'b00 : hit_q ? fwd_q : tbl_rdata_i;
endmodule

// File: tb/tb_bp_choice_table_sched.sv
// tb_bp_choice_table_sched: directed checks of sweep, forwarding, arbitration and mid-run reset.
module tb_bp_choice_table_sched;
    logic clk = 1'b0;
    logic rst;
    logic if_req, if_ready, if_rsp_valid, upd_valid, upd_ready;
    logic tbl_en, tbl_we, init_done;
    logic [5:0] if_idx, upd_idx, tbl_addr;
    logic [1:0] if_rsp_sel, upd_sel, tbl_wdata, tbl_rdata;
    logic [1:0] mem [0:63];
    logic [9:0] tbl;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_choice_table_sched #(.IDX_W(6), .QDEPTH(4), .INIT_SEL(2'b01)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req),
        .if_idx_i       (if_idx),
        .if_ready_o     (if_ready),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_sel_o   (if_rsp_sel),
        .upd_valid_i    (upd_valid),
        .upd_idx_i      (upd_idx),
        .upd_sel_i      (upd_sel),
        .upd_ready_o    (upd_ready),
        .tbl_en_o       (tbl_en),
        .tbl_we_o       (tbl_we),
        .tbl_addr_o     (tbl_addr),
        .tbl_wdata_o    (tbl_wdata),
        .tbl_rdata_i    (tbl_rdata),
        .init_done_o    (init_done)
    );

    // single-port table with one-cycle read latency
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else tbl_rdata <= mem[tbl_addr];
        end
    end

    assign tbl = {tbl_en, tbl_we, tbl_addr, tbl_wdata};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rq, input logic [5:0] ri, input logic uv,
                         input logic [5:0] ui, input logic [1:0] us);
        if_req    = rq;
        if_idx    = ri;
        upd_valid = uv;
        upd_idx   = ui;
        upd_sel   = us;
    endtask

    task automatic sweep_check;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk("sweep", {init_done, if_ready, upd_ready, tbl}, {3'b000, 2'b11, 6'(i), 2'b01});
            tick;
        end
        #1;
        chk("init_done", {init_done, if_ready, upd_ready}, 3'b111);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick;
        tick;
        #1;
        chk("reset_out", {if_ready, upd_ready, if_rsp_valid, if_rsp_sel, tbl_en, tbl_we, init_done}, 8'h00);
        tick;
        rst = 1'b0;
        sweep_check;
        chk("sweep_mem", {mem[0], mem[5], mem[63]}, 6'b010101);

        // read-after-update in the same cycle
        drive(1, 5, 1, 5, 2'b11);
        #1;
        chk("raw_rd", {if_ready, upd_ready, tbl_en, tbl_we, tbl_addr}, {4'b1110, 6'd5});
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("raw_rsp", {if_rsp_valid, if_rsp_sel}, 3'b111);
        chk("raw_mem_old", mem[5], 2'b01);
        chk("raw_drain", tbl, {2'b11, 6'd5, 2'b11});
        tick;
        #1;
        chk("raw_mem_new", mem[5], 2'b11);
        chk("raw_idle", tbl_en, 1'b0);

        // two updates to the same index, youngest forwarded
        drive(1, 20, 1, 9, 2'b00);
        #1;
        chk("yw_rd20", {if_ready, tbl_en, tbl_we, tbl_addr}, {3'b110, 6'd20});
        tick;
        drive(1, 21, 1, 9, 2'b10);
        #1;
        chk("yw_rsp20", {if_rsp_valid, if_rsp_sel}, 3'b101);
        tick;
        drive(1, 9, 0, 0, 0);
        #1;
        chk("yw_rsp21", {if_rsp_valid, if_rsp_sel}, 3'b101);
        chk("yw_rd9", {tbl_en, tbl_we, tbl_addr}, {2'b10, 6'd9});
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("yw_rsp9", {if_rsp_valid, if_rsp_sel}, 3'b110);
        chk("yw_drain0", tbl, {2'b11, 6'd9, 2'b00});
        tick;
        #1;
        chk("yw_drain1", {if_rsp_valid, tbl}, {3'b011, 6'd9, 2'b10});
        tick;
        #1;
        chk("yw_idle", tbl_en, 1'b0);

        // fill the FIFO under continuous lookups
        for (int k = 0; k < 4; k++) begin
            drive(1, 30, 1, 6'(40 + k), 2'(k));
            #1;
            chk("full_fill", {if_ready, upd_ready, tbl_en, tbl_we}, 4'b1110);
            tick;
        end
        drive(1, 30, 0, 0, 0);
        #1;
        chk("full_rdy", {if_ready, upd_ready}, 2'b00);
        chk("full_drain", tbl, {2'b11, 6'd40, 2'b00});
        tick;
        #1;
        chk("full_back", {if_ready, upd_ready, if_rsp_valid}, 3'b110);
        chk("full_rd", {tbl_en, tbl_we, tbl_addr}, {2'b10, 6'd30});
        tick;
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("full_order", tbl, {2'b11, 6'(40 + k), 2'(k)});
            tick;
        end
        #1;
        chk("full_idle", tbl_en, 1'b0);

        // idle drains while pushing every cycle
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 6'(50 + k), 2'(k + 1));
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 6'(53 + k), 2'(k));
            #1;
            chk("pd_drain", {upd_ready, tbl}, {3'b111, 6'(50 + k), 2'(k + 1)});
            tick;
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pd_tail", tbl, {2'b11, 6'(53 + k), 2'(k)});
            tick;
        end
        #1;
        chk("pd_empty", tbl_en, 1'b0);

        // reset with two queued writes and a lookup in flight
        drive(1, 7, 1, 60, 2'b11);
        tick;
        drive(1, 7, 1, 61, 2'b11);
        tick;
        drive(1, 60, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_tbl", tbl_en, 1'b0);
        tick;
        #1;
        chk("rst_out", {if_rsp_valid, if_rsp_sel, if_ready, upd_ready, init_done, tbl_en}, 7'h00);
        tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        sweep_check;
        #1;
        chk("rst_fifo_empty", tbl_en, 1'b0);
        chk("rst_mem", {mem[60], mem[61]}, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
